dpsk_diff_tx: RTL and testbench
===============================

# dpsk_diff_tx

Transmit-side framer and differential encoder for the DPSK link. It takes payload bytes over a valid/ready handshake, frames them as a preamble, a sync word and the payload, and differentially encodes the result. The output is an NRZ bit stream at a fixed bit rate, and the receive-side DPLL bit synchronizer locks onto it. The block sits after the clock divider and drives the modulator's data input.

## Interface
- CLK_DIV, default 20: clk1 cycles per bit (20 gives 50 kbps at a 1 MHz clk1). Must be ≥ 2.
- PREAMBLE_BITS, default 32: number of raw '1' bits sent before the sync word. Must be ≥ 1.
- SYNC_WORD, default 16'hEB90: 16-bit frame sync pattern, sent MSB first.
- clk1 in 1: the only clock; every register is clocked on its rising edge.
- rst_n_i in 1: asynchronous, active-low reset.
- tx_data_i in 8: payload byte.
- tx_valid_i in 1: tx_data_i is valid.
- tx_ready_o out 1: the byte buffer is empty (equal to ~buf_full).
- data_o out 1: differentially encoded NRZ output, registered.
- bit_stb_o out 1: one-cycle pulse on the first cycle of every transmitted bit.
- busy_o out 1: high whenever the state is not IDLE.

## Operation
- Differential rule: a raw bit of 1 toggles data_o; a raw bit of 0 holds data_o. The level carries across frames.
- One-byte holding buffer:
  - Accept a byte on a clk1 edge where tx_valid_i && tx_ready_o; buf_full then sets.
  - buf_full clears when the shifter loads the byte.
- The FSM states are IDLE, PREAMBLE, SYNC and PAYLOAD.
- IDLE:
  - Divider held at 0, data_o holds its level, bit_stb_o = 0.
  - On buf_full, go to PREAMBLE and emit the first bit on the next edge.
- PREAMBLE: send PREAMBLE_BITS raw 1s, which gives maximum edge density for DPLL pull-in. Then go to SYNC.
- SYNC: send SYNC_WORD[15] down to SYNC_WORD[0]. Then go to PAYLOAD and load the buffer into the 8-bit shifter.
- PAYLOAD:
  - Send the shifter MSB first.
  - At the end of bit 7, if buf_full is set, load the next byte and continue with no gap.
  - Otherwise, go to IDLE.
- A bit counter counts 0..7 for payload bits and 0..max(PREAMBLE_BITS,16)-1 for preamble and sync bits.
- Bit boundary: div_cnt == CLK_DIV-1. div_cnt wraps to 0 and the next raw bit is applied to data_o on that same edge.
- Reset:
  - Asserting rst_n_i aborts immediately, including mid-frame. Any buffered byte is discarded.
  - State goes to IDLE.
  - Output values during reset: data_o = 0, bit_stb_o = 0, busy_o = 0, tx_ready_o = 1.

## Timing
- Every bit lasts exactly CLK_DIV clk1 cycles, with no jitter and no dropped or stretched bits.
- Start-up latency: a byte accepted at edge k while IDLE puts the first preamble bit on data_o at edge k+1, with bit_stb_o = 1 in that cycle.
- The first payload bit starts (PREAMBLE_BITS+16)·CLK_DIV cycles after the first preamble bit.
- Buffer load occurs on the edge that starts bit 0 of a byte. tx_ready_o goes high on the cycle after that edge.
- Gapless streaming: the next byte must be accepted before the edge that starts the following byte's bit 0. The window is 8·CLK_DIV−1 cycles.
- If tx_valid_i arrives on the exact end-of-byte edge, it counts as too late: the frame ends, and the byte starts a new frame with a fresh preamble.
- tx_ready_o is never high while buf_full = 1, so accept and load cannot collide.
- busy_o falls on the same edge at which the state returns to IDLE, which is the end of the last bit.

## Structure
- Shared package dpsk_pkg:
  - State enum tx_state_t with members IDLE, PREAMBLE, SYNC, PAYLOAD.
  - Default SYNC_WORD constant 16'hEB90, also used by the receive-side frame detector.
  - Constant DIFF_TOGGLE_ON_ONE = 1, fixing the encoding rule for both ends.
- One sub-module, bit_tick_gen:
  - Parameter CLK_DIV; inputs en and clear; output tick on the bit boundary.
  - It holds the divider logic.
- Everything else stays in the top level.

## Test plan
The bench uses CLK_DIV = 4 and PREAMBLE_BITS = 8.
- Reset, then send byte 8'hA5.
  - Preamble: data_o = 1,0,1,0,1,0,1,0.
  - Sync 0xEB90: data_o = 1,0,1,1,0,0,1,0,1,1,1,0,0,0,0,0.
  - Payload: data_o = 1,1,0,0,0,1,1,0.
  - Then busy_o falls; 32 bits sent in total.
- Check every bit_stb_o spacing equals 4 cycles. Check the first strobe comes 1 cycle after acceptance.
- Stream 8'h00, 8'hFF, 8'h3C, each accepted within its window.
  - Payload is contiguous with no second preamble.
  - Exactly 24 payload bits are sent; 8'hFF toggles data_o 8 times.
- Present the second byte exactly on the end-of-byte edge.
  - The frame ends and busy_o drops.
  - A new 8-bit preamble follows.
- Assert rst_n_i low mid-sync with a byte buffered.
  - Outputs immediately go to data_o = 0, busy_o = 0, tx_ready_o = 1.
  - The buffered byte is never transmitted.
- Hold tx_valid_i high while buf_full is set.
  - tx_ready_o stays 0 and no overwrite occurs.
  - The data transmitted matches the first byte.

Source files
------------

// File: rtl/dpsk_pkg.sv
// Shared DPSK link definitions.
// Used by the transmit framer and the receive-side frame detector.
package dpsk_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PREAMBLE,
    SYNC,
    PAYLOAD
  } tx_state_t;

  localparam logic [15:0] DEFAULT_SYNC_WORD = 16'hEB90;
  localparam logic DIFF_TOGGLE_ON_ONE = 1'b1;

  // Next line level for one raw bit under the link's encoding rule.
  function automatic logic diff_next(
    input logic lvl,
    input logic raw
  );
    if (DIFF_TOGGLE_ON_ONE)
      return lvl ^ raw;
    else
      return lvl ^ ~raw;
  endfunction

endpackage

// File: rtl/dpsk_diff_tx_bit_tick_gen.sv
// Bit-period divider: tick marks the last clk1 cycle of each bit.
// Held at zero by clear so a frame starts on a fresh bit period.
module bit_tick_gen #(
  parameter int CLK_DIV = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clear,
  output logic tick
);

  localparam int W = $clog2(CLK_DIV);
  localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);

  logic [W-1:0] div_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (clear) begin
      div_cnt <= '0;
    end else if (en) begin
      if (div_cnt == LAST)
        div_cnt <= '0;
      else
        div_cnt <= div_cnt + W'(1);
    end
  end

  assign tick = en && !clear && (div_cnt == LAST);

endmodule

// File: rtl/dpsk_diff_tx.sv
// DPSK transmit framer: preamble, sync word and payload bytes,
// differentially encoded onto a fixed-rate NRZ line.
module dpsk_diff_tx
  import dpsk_pkg::*;
#(
  parameter int          CLK_DIV       = 20,
  parameter int          PREAMBLE_BITS = 32,
  parameter logic [15:0] SYNC_WORD     = DEFAULT_SYNC_WORD
) (
  input  logic       clk1,
  input  logic       rst_n_i,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  output logic       data_o,
  output logic       bit_stb_o,
  output logic       busy_o
);

  localparam int SEQ_BITS =
    (PREAMBLE_BITS > 16) ? PREAMBLE_BITS : 16;
  localparam int CW = $clog2(SEQ_BITS);
  localparam logic [CW-1:0] PRE_LAST =
    CW'(PREAMBLE_BITS - 1);
  localparam logic [CW-1:0] SYNC_LAST = CW'(15);
  localparam logic [CW-1:0] BYTE_LAST = CW'(7);

  tx_state_t     state;
  logic [CW-1:0] bit_cnt;
  logic [7:0]    buf_data;
  logic [7:0]    shifter;
  logic          buf_full;
  logic          active;
  logic          tick;
  logic          accept;
  logic          load;
  logic [3:0]    sync_idx;

  assign active     = (state != IDLE);
  assign busy_o     = active;
  assign tx_ready_o = ~buf_full;
  assign accept     = tx_valid_i && !buf_full;

  // Buffer moves into the shifter on the edge starting payload bit 0.
  assign load = tick && buf_full &&
    ((state == SYNC && bit_cnt == SYNC_LAST) ||
     (state == PAYLOAD && bit_cnt == BYTE_LAST));

  // Index of the sync bit that follows the current one.
  assign sync_idx = ~(bit_cnt[3:0] + 4'd1);

  bit_tick_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_tick (
    .clk  (clk1),
    .rst_n(rst_n_i),
    .en   (active),
    .clear(!active),
    .tick (tick)
  );

  always_ff @(posedge clk1 or negedge rst_n_i) begin
    if (!rst_n_i) begin
      buf_full <= 1'b0;
      buf_data <= '0;
    end else if (accept) begin
      buf_full <= 1'b1;
      buf_data <= tx_data_i;
    end else if (load) begin
      buf_full <= 1'b0;
    end
  end

  always_ff @(posedge clk1 or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shifter   <= '0;
      data_o    <= 1'b0;
      bit_stb_o <= 1'b0;
    end else begin
      bit_stb_o <= 1'b0;
      unique case (state)
        IDLE: begin
          if (buf_full) begin
            state     <= PREAMBLE;
            bit_cnt   <= '0;
            bit_stb_o <= 1'b1;
            data_o    <= diff_next(data_o, 1'b1);
          end
        end
        PREAMBLE: begin
          if (tick) begin
            bit_stb_o <= 1'b1;
            if (bit_cnt == PRE_LAST) begin
              state   <= SYNC;
              bit_cnt <= '0;
              data_o  <= diff_next(data_o, SYNC_WORD[15]);
            end else begin
              bit_cnt <= bit_cnt + CW'(1);
              data_o  <= diff_next(data_o, 1'b1);
            end
          end
        end
        SYNC: begin
          if (tick) begin
            bit_stb_o <= 1'b1;
            if (bit_cnt == SYNC_LAST) begin
              state   <= PAYLOAD;
              bit_cnt <= '0;
              shifter <= buf_data;
              data_o  <= diff_next(data_o, buf_data[7]);
            end else begin
              bit_cnt <= bit_cnt + CW'(1);
              data_o  <= diff_next(data_o, SYNC_WORD[sync_idx]);
            end
          end
        end
        PAYLOAD: begin
          if (tick) begin
            if (bit_cnt == BYTE_LAST) begin
              if (buf_full) begin
                bit_stb_o <= 1'b1;
                bit_cnt   <= '0;
                shifter   <= buf_data;
                data_o    <= diff_next(data_o, buf_data[7]);
              end else begin
                state <= IDLE;
              end
            end else begin
              bit_stb_o <= 1'b1;
              bit_cnt   <= bit_cnt + CW'(1);
              shifter   <= {shifter[6:0], 1'b0};
              data_o    <= diff_next(data_o, shifter[6]);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dpsk_diff_tx.sv
// Self-checking bench for dpsk_diff_tx with a line-level scoreboard.
// Expected levels are queued at stimulus time, popped on each bit strobe.
module tb_dpsk_diff_tx;

  localparam int CLK_DIV = 4;
  localparam int PRE = 8;
  localparam logic [15:0] SW = 16'hEB90;

  logic       clk1 = 1'b0;
  logic       rst_n_i = 1'b0;
  logic [7:0] tx_data_i = '0;
  logic       tx_valid_i = 1'b0;
  logic       tx_ready_o;
  logic       data_o;
  logic       bit_stb_o;
  logic       busy_o;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   stb_total = 0;
  int   last_stb = 0;
  logic in_run = 1'b0;
  logic model_lvl = 1'b0;
  logic exp_q[$];
  logic [31:0] a5_levels = 32'hAAB2E0C6;

  always #5 clk1 = ~clk1;

  dpsk_diff_tx #(
    .CLK_DIV      (CLK_DIV),
    .PREAMBLE_BITS(PRE),
    .SYNC_WORD    (SW)
  ) dut (
    .clk1      (clk1),
    .rst_n_i   (rst_n_i),
    .tx_data_i (tx_data_i),
    .tx_valid_i(tx_valid_i),
    .tx_ready_o(tx_ready_o),
    .data_o    (data_o),
    .bit_stb_o (bit_stb_o),
    .busy_o    (busy_o)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic push_raw(input logic b);
    model_lvl = model_lvl ^ b;
    exp_q.push_back(model_lvl);
  endtask

  task automatic push_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) push_raw(b[i]);
  endtask

  task automatic push_frame(input logic [7:0] b);
    for (int i = 0; i < PRE; i++) push_raw(1'b1);
    for (int i = 15; i >= 0; i--) push_raw(SW[i]);
    push_byte(b);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    while (!tx_ready_o && n < 2000) begin
      @(posedge clk1); #1;
      n++;
    end
    if (!tx_ready_o) chk("rdy_to", tx_ready_o, 1);
    tx_data_i  = b;
    tx_valid_i = 1'b1;
    @(posedge clk1); #1;
    tx_valid_i = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy_o && n < 2000) begin
      @(posedge clk1); #1;
      n++;
    end
    if (busy_o) chk("idle_to", busy_o, 0);
  endtask

  task automatic wait_stb(input int target);
    int n = 0;
    while (stb_total < target && n < 2000) begin
      @(posedge clk1);
      n++;
    end
    if (stb_total < target) chk("stb_to", stb_total, target);
  endtask

  always @(posedge clk1) cyc <= cyc + 1;

  always @(negedge clk1) begin
    if (rst_n_i && bit_stb_o) begin
      if (exp_q.size() == 0)
        chk("extra_bit", exp_q.size(), 1);
      else
        chk("bit", data_o, exp_q.pop_front());
      if (in_run) chk("stb_gap", cyc - last_stb, CLK_DIV);
      stb_total <= stb_total + 1;
      last_stb  <= cyc;
    end
    in_run <= rst_n_i && busy_o && (bit_stb_o || in_run);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    #12;
    chk("rst_data", data_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_ready", tx_ready_o, 1);
    chk("rst_stb", bit_stb_o, 0);
    @(posedge clk1); #1;
    rst_n_i = 1'b1;

    // single byte A5 against the literal line levels
    repeat (3) @(posedge clk1);
    #1;
    base = stb_total;
    for (int i = 31; i >= 0; i--) exp_q.push_back(a5_levels[i]);
    model_lvl = 1'b0;
    send_byte(8'hA5);
    chk("rdy_after_acc", tx_ready_o, 0);
    @(negedge clk1);
    chk("stb_early", bit_stb_o, 0);
    @(negedge clk1);
    chk("stb_first", bit_stb_o, 1);
    chk("busy_first", busy_o, 1);
    @(posedge clk1); #1;
    wait_idle();
    chk("a5_bits", stb_total - base, 32);
    chk("a5_q", exp_q.size(), 0);
    chk("a5_rdy", tx_ready_o, 1);

    // gapless stream of three bytes
    repeat (5) @(posedge clk1);
    #1;
    base = stb_total;
    push_frame(8'h00);
    send_byte(8'h00);
    push_byte(8'hFF);
    send_byte(8'hFF);
    push_byte(8'h3C);
    send_byte(8'h3C);
    wait_idle();
    chk("stream_bits", stb_total - base, PRE + 16 + 24);
    chk("stream_q", exp_q.size(), 0);

    // byte offered exactly on the end-of-byte edge
    repeat (5) @(posedge clk1);
    #1;
    base = stb_total;
    push_frame(8'h96);
    send_byte(8'h96);
    wait_stb(base + PRE + 16 + 8);
    repeat (2) @(posedge clk1);
    #1;
    tx_data_i  = 8'h69;
    tx_valid_i = 1'b1;
    @(posedge clk1); #1;
    tx_valid_i = 1'b0;
    chk("late_busy", busy_o, 0);
    chk("late_held", tx_ready_o, 0);
    chk("late_q0", exp_q.size(), 0);
    push_frame(8'h69);
    @(posedge clk1); #1;
    chk("late_restart", busy_o, 1);
    chk("late_stb", bit_stb_o, 1);
    wait_idle();
    chk("late_bits", stb_total - base, 64);
    chk("late_q", exp_q.size(), 0);

    // reset mid-sync with a byte still buffered
    repeat (5) @(posedge clk1);
    #1;
    base = stb_total;
    push_frame(8'h81);
    send_byte(8'h81);
    wait_stb(base + PRE + 4);
    #2;
    rst_n_i = 1'b0;
    #1;
    chk("mid_rst_data", data_o, 0);
    chk("mid_rst_busy", busy_o, 0);
    chk("mid_rst_ready", tx_ready_o, 1);
    chk("mid_rst_stb", bit_stb_o, 0);
    exp_q.delete();
    model_lvl = 1'b0;
    repeat (3) @(posedge clk1);
    #3;
    rst_n_i = 1'b1;
    base = stb_total;
    repeat (150) @(posedge clk1);
    #1;
    chk("no_stale_bits", stb_total - base, 0);
    chk("post_rst_busy", busy_o, 0);
    chk("post_rst_ready", tx_ready_o, 1);

    // valid held high while the buffer is full
    base = stb_total;
    push_frame(8'h5A);
    tx_data_i  = 8'h5A;
    tx_valid_i = 1'b1;
    @(posedge clk1); #1;
    tx_data_i = 8'hC3;
    for (int i = 0; i < 5; i++) begin
      repeat (8) @(posedge clk1);
      #1;
      chk("hold_rdy", tx_ready_o, 0);
    end
    tx_valid_i = 1'b0;
    wait_idle();
    chk("hold_bits", stb_total - base, 32);
    chk("hold_q", exp_q.size(), 0);

    repeat (4) @(posedge clk1);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
